// File: rtl/router_out_port_arbiter_pkg.sv
// Shared flit encodings, port indices and FSM state type for the mesh router output-port arbiter.
// Pure definitions, no latency or backpressure of its own.
package router_out_port_arbiter_pkg;

  localparam logic [2:0] FLIT_HEADER = 3'b001;
  localparam logic [2:0] FLIT_BODY   = 3'b010;
  localparam logic [2:0] FLIT_TAIL   = 3'b100;

  // Input port ordering used across the router
  localparam int PORT_N = 0;
  localparam int PORT_E = 1;
  localparam int PORT_W = 2;
  localparam int PORT_S = 3;
  localparam int PORT_L = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/router_out_port_arbiter_rr_arbiter.sv
// Round-robin picker: first eligible input at or after rr_ptr, wrapping; combinational, 0 cycles.
// No backpressure; the caller decides when to register the winner.
module router_out_port_arbiter_rr_arbiter
  import router_out_port_arbiter_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int SEL_W = 2
) (
  input  logic [N_IN-1:0]  eligible,
  input  logic [SEL_W-1:0] rr_ptr,
  output logic [N_IN-1:0]  winner,
  output logic [SEL_W-1:0] win_idx,
  output logic             win_vld
);

  always_comb begin
    logic [SEL_W:0]   pos;
    logic [SEL_W-1:0] idx;
    pos     = '0;
    idx     = '0;
    winner  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      pos = {1'b0, rr_ptr} + (SEL_W+1)'(k);
      if (pos >= (SEL_W+1)'(N_IN)) pos = pos - (SEL_W+1)'(N_IN);
      idx = pos[SEL_W-1:0];
      if (!win_vld && eligible[idx]) begin
        win_vld     = 1'b1;
        winner[idx] = 1'b1;
        win_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/router_out_port_arbiter.sv
// Wormhole output-port allocator: 1-cycle round-robin grant on a HEADER, lock held until TAIL.
// Pops the owner's FIFO only when it is non-empty and dn_full is low; stalls hold the lock.
module router_out_port_arbiter
  import router_out_port_arbiter_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int SEL_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_IN-1:0]     req,
  input  logic [N_IN-1:0]     empty,
  input  logic [3*N_IN-1:0]   flit_type,
  input  logic                dn_full,
  output logic [N_IN-1:0]     grant,
  output logic [SEL_W-1:0]    sel,
  output logic [N_IN-1:0]     rd_en,
  output logic                valid_out,
  output logic                busy
);

  arb_state_t       state, state_d;
  logic [N_IN-1:0]  grant_d;
  logic [SEL_W-1:0] sel_d;
  logic [SEL_W-1:0] rr_ptr, rr_ptr_d;

  logic [2:0]       head_type [N_IN];
  logic [N_IN-1:0]  eligible;
  logic [N_IN-1:0]  winner;
  logic [SEL_W-1:0] win_idx;
  logic             win_vld;

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    assign head_type[i] = flit_type[3*i +: 3];
    assign eligible[i]  = req[i] & ~empty[i] & (head_type[i] == FLIT_HEADER);
  end

  router_out_port_arbiter_rr_arbiter #(
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_rr (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .winner   (winner),
    .win_idx  (win_idx),
    .win_vld  (win_vld)
  );

  assign busy = (state == ST_LOCKED);

  // Gating with rst keeps an abandoned packet from losing a flit in the reset cycle
  always_comb begin
    valid_out = busy & ~rst & ~empty[sel] & ~dn_full;
    rd_en     = '0;
    if (valid_out) rd_en[sel] = 1'b1;
  end

  always_comb begin
    state_d  = state;
    grant_d  = grant;
    sel_d    = sel;
    rr_ptr_d = rr_ptr;
    case (state)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = ST_LOCKED;
          grant_d = winner;
          sel_d   = win_idx;
        end
      end
      ST_LOCKED: begin
        // A stray HEADER mid-packet is forwarded as payload; only TAIL releases
        if (valid_out && (head_type[sel] == FLIT_TAIL)) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          sel_d    = '0;
          rr_ptr_d = (sel == SEL_W'(N_IN-1)) ? '0 : sel + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      grant  <= '0;
      sel    <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_d;
      grant  <= grant_d;
      sel    <= sel_d;
      rr_ptr <= rr_ptr_d;
    end
  end

endmodule

// File: doc/router_out_port_arbiter.md
Name: router_out_port_arbiter

Overview:
- Per-output-port switch allocator for the 2x2 mesh router.
- Receives per-input-port requests from the LBDR stage of every input port and grants the output port to one input, round-robin.
- Holds the grant for the whole packet (HEADER through TAIL), wormhole style.
- Drives the input-FIFO pop strobes and the crossbar select, and stalls on downstream full.

Parameters:
- N_IN, 4: number of requesting input ports. Range 2..5.
- SEL_W, 2: width of the crossbar select, equal to clog2(N_IN).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- req  input  N_IN  req[i]=1 means input i's LBDR selected this output port.
- empty  input  N_IN  input FIFO i is empty.
- flit_type  input  3*N_IN  flit type at the head of FIFO i, in bits [3i+2:3i]; encodings are `HEADER, `BODY, `TAIL.
- dn_full  input  1  downstream buffer cannot accept a flit this cycle.
- grant  output  N_IN  one-hot owner of the output port; all-zero when idle.
- sel  output  SEL_W  binary index of the owner; feeds the crossbar mux.
- rd_en  output  N_IN  pop strobe to input FIFO i.
- valid_out  output  1  a flit crosses to the output this cycle.
- busy  output  1  port is locked to a packet.

Behaviour:
- Reset values: grant=0, sel=0, rd_en=0, valid_out=0, busy=0, state=IDLE, rr_ptr=0.
- FSM has two states, IDLE and LOCKED.
- Eligibility in IDLE: input i is eligible when req[i] & ~empty[i] & (flit_type_i == `HEADER).
  - Requests whose head flit is not a HEADER are ignored.
- IDLE arbitration:
  - Search eligible inputs starting at rr_ptr, ascending, wrapping at N_IN-1 to 0.
  - Register the first hit as the winner: grant, sel and busy=1 from the next cycle. State becomes LOCKED.
  - No pop happens in the arbitration cycle.
  - Arbitration latency is exactly 1 cycle from eligibility to grant.
- LOCKED transfer:
  - With g = sel: rd_en[g] = valid_out = ~empty[g] & ~dn_full. This is combinational from registered state.
  - All other rd_en bits are 0.
  - req is ignored while LOCKED; the packet is held until its TAIL.
- Packet release:
  - When valid_out=1 and flit_type_g == `TAIL, the next cycle has state=IDLE, grant=0, busy=0 and rr_ptr=(g+1) mod N_IN.
  - The released port can be re-granted no earlier than the following cycle, so there is 1 idle bubble between packets. This is required.
- Stalls:
  - empty[g]=1 or dn_full=1 gives valid_out=0 and the lock is retained. There is no timeout.
- Single-flit packet: a HEADER is never treated as a TAIL. A packet is always at least HEADER+TAIL.
- A HEADER observed at the owner's FIFO head while LOCKED is a protocol error:
  - It is forwarded like a BODY.
  - The assertion in the bench must flag it.
- Fairness: after a TAIL from input g, input g has the lowest priority in the next arbitration.
- rr_ptr changes only on TAIL release, never on an arbitration.
- Reset in any state forces the full reset values in the next cycle, including mid-packet.
  - The partial packet is abandoned; no pop is issued in the reset cycle.
- Invariants:
  - grant is always one-hot or zero.
  - popcount(rd_en) <= 1.
  - rd_en is never asserted while empty is 1 for that input.
  - valid_out == |rd_en.

Decomposition:
- Shared include (parameters.v): `HEADER, `BODY, `TAIL flit-type encodings (3 bits), `AXIS, and the port index constants (N, E, W, S, L ordering).
- One sub-module, rr_arbiter.
  - Purely combinational round-robin priority picker.
  - Inputs: eligible[N_IN] and rr_ptr. Outputs: one-hot winner and index.
- The FSM, lock and pop logic stay in router_out_port_arbiter.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, req=0 -> grant=0, rd_en=0, busy=0, sel=0 on every cycle.
2. Single requester, 3-flit packet: req=4'b0010, FIFO1 holds HEADER/BODY/TAIL, dn_full=0.
   - Grant 4'b0010 one cycle after req.
   - rd_en[1] high for 3 consecutive cycles.
   - busy drops the cycle after the TAIL pop; rr_ptr=2.
3. Contention and rotation: all 4 inputs request, each with a 2-flit packet, starting from rr_ptr=0.
   - Grant order is 0,1,2,3, each separated by 1 idle bubble.
   - No input gets a second grant before all others are served.
4. Backpressure mid-packet: owner input 2 has a 4-flit packet; dn_full=1 for 3 cycles after the HEADER pop.
   - rd_en=0 and valid_out=0 for those 3 cycles; grant stays 4'b0100.
   - The remaining 3 flits pop after dn_full falls.
5. Non-header request ignored: req[3]=1 with a BODY at FIFO3 head while IDLE -> no grant.
   - Change the head to HEADER -> grant=4'b1000 the next cycle.
6. Reset mid-packet: assert rst after the BODY pop of a 3-flit packet.
   - The next cycle is all reset values.
   - A new HEADER on input 0 after reset is granted with rr_ptr=0 priority.
